// File: rtl/updown_mod_counter_if.sv
// Control and status bundle for updown_mod_counter.
// master: drives en/mode/load/load_val/clr_flags, observes count and status.
// slave: the counter side of the same bundle.
interface updown_mod_counter_if #(
    parameter int WIDTH = 10
);
    logic             en;
    logic             mode;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             clr_flags;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             at_max;
    logic             at_min;
    logic             ovf;
    logic             unf;

    modport master (
        output en, mode, load, load_val, clr_flags,
        input  count, tc, at_max, at_min, ovf, unf
    );

    modport slave (
        input  en, mode, load, load_val, clr_flags,
        output count, tc, at_max, at_min, ovf, unf
    );
endinterface

// File: rtl/updown_mod_counter.sv
// Modulo up/down counter over [MIN_VAL, MAX_VAL] stepping by STEP.
// Ports: clk, rst (async active-low), bus (slave side of the bundle):
//   en/mode/load/load_val/clr_flags in; count/tc/at_max/at_min/ovf/unf out.
module updown_mod_counter #(
    parameter int WIDTH    = 10,
    parameter int MIN_VAL  = 0,
    parameter int MAX_VAL  = 999,
    parameter int STEP     = 1,
    parameter int SATURATE = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    updown_mod_counter_if.slave  bus
);
    localparam int XW = WIDTH + 1;

    localparam logic [WIDTH:0] MAX_X = XW'(MAX_VAL);
    localparam logic [WIDTH:0] MIN_X = XW'(MIN_VAL);
    localparam logic [WIDTH:0] STP_X = XW'(STEP);
    localparam logic [WIDTH:0] RNG_X = XW'(MAX_VAL - MIN_VAL + 1);
    // Compare against pre-shifted limits so neither side can wrap.
    localparam logic [WIDTH:0] UP_LIM = XW'(MAX_VAL - STEP);
    localparam logic [WIDTH:0] DN_LIM = XW'(MIN_VAL + STEP);

    localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_W = WIDTH'(MIN_VAL);

    logic [WIDTH-1:0] count_q;
    logic             tc_q;
    logic             ovf_q;
    logic             unf_q;

    logic [WIDTH:0] ext;
    logic [WIDTH:0] ld_ext;
    logic [WIDTH:0] ld_clamp;
    logic [WIDTH:0] up_next;
    logic [WIDTH:0] dn_next;
    logic [WIDTH:0] nxt_x;
    logic           up_x;
    logic           dn_x;
    logic           tc_d;
    logic           ovf_d;
    logic           unf_d;
    logic           unused_msb;

    always_comb begin
        ext    = {1'b0, count_q};
        ld_ext = {1'b0, bus.load_val};
        up_x   = ext > UP_LIM;
        dn_x   = ext < DN_LIM;

        if (ld_ext > MAX_X) begin
            ld_clamp = MAX_X;
        end else if (ld_ext < MIN_X) begin
            ld_clamp = MIN_X;
        end else begin
            ld_clamp = ld_ext;
        end

        if (!up_x) begin
            up_next = ext + STP_X;
        end else if (SATURATE != 0) begin
            up_next = MAX_X;
        end else begin
            up_next = ext + STP_X - RNG_X;
        end

        if (!dn_x) begin
            dn_next = ext - STP_X;
        end else if (SATURATE != 0) begin
            dn_next = MIN_X;
        end else begin
            dn_next = ext + RNG_X - STP_X;
        end
    end

    always_comb begin
        nxt_x = ext;
        tc_d  = 1'b0;
        // A crossing in the same cycle overrides clr_flags below.
        ovf_d = bus.clr_flags ? 1'b0 : ovf_q;
        unf_d = bus.clr_flags ? 1'b0 : unf_q;

        if (bus.load) begin
            nxt_x = ld_clamp;
        end else if (bus.en && !bus.mode) begin
            nxt_x = up_next;
            if (up_x) begin
                tc_d  = 1'b1;
                ovf_d = 1'b1;
            end
        end else if (bus.en) begin
            nxt_x = dn_next;
            if (dn_x) begin
                tc_d  = 1'b1;
                unf_d = 1'b1;
            end
        end
    end

    assign unused_msb = nxt_x[WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= MIN_W;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= nxt_x[WIDTH-1:0];
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.count  = count_q;
    assign bus.tc     = tc_q;
    assign bus.ovf    = ovf_q;
    assign bus.unf    = unf_q;
    assign bus.at_max = count_q == MAX_W;
    assign bus.at_min = count_q == MIN_W;
endmodule

// File: tb/tb_updown_mod_counter.sv
// Scoreboard bench for updown_mod_counter: three instances
// (default wrap, saturating, STEP=3 over [2,11]).
module tb_updown_mod_counter;
    logic clk;
    logic rst;

    updown_mod_counter_if #(.WIDTH(10)) i0 ();
    updown_mod_counter_if #(.WIDTH(10)) i1 ();
    updown_mod_counter_if #(.WIDTH(10)) i2 ();

    updown_mod_counter #(
        .WIDTH(10), .MIN_VAL(0), .MAX_VAL(999), .STEP(1), .SATURATE(0)
    ) d0 (.clk(clk), .rst(rst), .bus(i0.slave));

    updown_mod_counter #(
        .WIDTH(10), .MIN_VAL(0), .MAX_VAL(999), .STEP(1), .SATURATE(1)
    ) d1 (.clk(clk), .rst(rst), .bus(i1.slave));

    updown_mod_counter #(
        .WIDTH(10), .MIN_VAL(2), .MAX_VAL(11), .STEP(3), .SATURATE(0)
    ) d2 (.clk(clk), .rst(rst), .bus(i2.slave));

    typedef struct {
        int         id;
        logic [9:0] cnt;
        logic       tc;
        logic       ovf;
        logic       unf;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [9:0] maxv(input int id);
        return (id == 2) ? 10'd11 : 10'd999;
    endfunction

    function automatic logic [9:0] minv(input int id);
        return (id == 2) ? 10'd2 : 10'd0;
    endfunction

    task automatic idle_all();
        i0.en = 0; i0.mode = 0; i0.load = 0; i0.load_val = 0; i0.clr_flags = 0;
        i1.en = 0; i1.mode = 0; i1.load = 0; i1.load_val = 0; i1.clr_flags = 0;
        i2.en = 0; i2.mode = 0; i2.load = 0; i2.load_val = 0; i2.clr_flags = 0;
    endtask

    // One clock of stimulus on instance id plus the expected post-edge state.
    task automatic cyc(input int id, input logic en, input logic mode,
                       input logic load, input logic [9:0] lv,
                       input logic clr, input logic [9:0] ec,
                       input logic etc, input logic eo, input logic eu);
        exp_t e;
        @(negedge clk);
        idle_all();
        case (id)
            0: begin
                i0.en = en; i0.mode = mode; i0.load = load;
                i0.load_val = lv; i0.clr_flags = clr;
            end
            1: begin
                i1.en = en; i1.mode = mode; i1.load = load;
                i1.load_val = lv; i1.clr_flags = clr;
            end
            default: begin
                i2.en = en; i2.mode = mode; i2.load = load;
                i2.load_val = lv; i2.clr_flags = clr;
            end
        endcase
        e.id = id; e.cnt = ec; e.tc = etc; e.ovf = eo; e.unf = eu;
        q.push_back(e);
    endtask

    // Monitor: pops one expectation per clock whenever one is pending.
    initial begin
        exp_t       e;
        logic [9:0] c;
        logic [4:0] st;
        forever begin
            @(posedge clk);
            #2;
            if (q.size() != 0) begin
                e = q.pop_front();
                case (e.id)
                    0: begin
                        c  = i0.count;
                        st = {i0.tc, i0.ovf, i0.unf, i0.at_max, i0.at_min};
                    end
                    1: begin
                        c  = i1.count;
                        st = {i1.tc, i1.ovf, i1.unf, i1.at_max, i1.at_min};
                    end
                    default: begin
                        c  = i2.count;
                        st = {i2.tc, i2.ovf, i2.unf, i2.at_max, i2.at_min};
                    end
                endcase
                chk($sformatf("count[d%0d]", e.id), 16'(c), 16'(e.cnt));
                chk($sformatf("tc_ovf_unf_max_min[d%0d]", e.id), 16'(st),
                    16'({e.tc, e.ovf, e.unf,
                         e.cnt == maxv(e.id), e.cnt == minv(e.id)}));
            end
        end
    end

    initial begin
        int n;
        rst = 1'b0;
        idle_all();
        repeat (3) @(negedge clk);
        chk("rst_count_d0", 16'(i0.count), 16'd0);
        chk("rst_count_d2", 16'(i2.count), 16'd2);
        chk("rst_flags_d0", 16'({i0.tc, i0.ovf, i0.unf}), 16'd0);
        chk("rst_min_d2", 16'({i2.at_min, i2.at_max}), 16'b10);
        rst = 1'b1;

        // Full wrap-around count on the default instance.
        for (int i = 1; i <= 1000; i++) begin
            cyc(0, 1, 0, 0, 0, 0, 10'(i % 1000), i == 1000, i == 1000, 0);
        end

        // Load 5, count down through the lower bound.
        cyc(0, 0, 0, 1, 10'd5, 0, 10'd5, 0, 1, 0);
        cyc(0, 1, 1, 0, 0, 0, 10'd4, 0, 1, 0);
        cyc(0, 1, 1, 0, 0, 0, 10'd3, 0, 1, 0);
        cyc(0, 1, 1, 0, 0, 0, 10'd2, 0, 1, 0);
        cyc(0, 1, 1, 0, 0, 0, 10'd1, 0, 1, 0);
        cyc(0, 1, 1, 0, 0, 0, 10'd0, 0, 1, 0);
        cyc(0, 1, 1, 0, 0, 0, 10'd999, 1, 1, 1);
        cyc(0, 1, 1, 0, 0, 0, 10'd998, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 1, 10'd998, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 10'd998, 0, 0, 0);

        // Load clamping and load-over-enable priority.
        cyc(0, 0, 0, 1, 10'd1023, 0, 10'd999, 0, 0, 0);
        cyc(0, 1, 1, 1, 10'd7, 0, 10'd7, 0, 0, 0);

        // Clear racing an overflow: the overflow wins.
        cyc(0, 0, 0, 1, 10'd999, 0, 10'd999, 0, 0, 0);
        cyc(0, 1, 0, 0, 0, 1, 10'd0, 1, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 10'd1, 0, 1, 0);
        cyc(0, 1, 0, 0, 0, 0, 10'd2, 0, 1, 0);

        // Asynchronous reset mid-count.
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_count", 16'(i0.count), 16'd0);
        chk("async_rst_flags", 16'({i0.tc, i0.ovf, i0.unf}), 16'd0);
        @(posedge clk);
        #1;
        chk("rst_held_count", 16'(i0.count), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        idle_all();
        cyc(0, 1, 0, 0, 0, 0, 10'd1, 0, 0, 0);

        // Saturating instance.
        cyc(1, 0, 0, 1, 10'd998, 0, 10'd998, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 10'd999, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 10'd999, 1, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 10'd999, 1, 1, 0);
        cyc(1, 1, 0, 0, 0, 0, 10'd999, 1, 1, 0);
        cyc(1, 0, 0, 0, 0, 0, 10'd999, 0, 1, 0);
        cyc(1, 0, 0, 1, 10'd1, 0, 10'd1, 0, 1, 0);
        cyc(1, 1, 1, 0, 0, 0, 10'd0, 0, 1, 0);
        cyc(1, 1, 1, 0, 0, 0, 10'd0, 1, 1, 1);

        // STEP=3 over [2,11], range 10.
        cyc(2, 0, 0, 1, 10'd10, 0, 10'd10, 0, 0, 0);
        cyc(2, 1, 0, 0, 0, 0, 10'd3, 1, 1, 0);
        cyc(2, 1, 1, 0, 0, 0, 10'd10, 1, 1, 1);
        cyc(2, 1, 1, 0, 0, 0, 10'd7, 0, 1, 1);
        cyc(2, 0, 0, 1, 10'd0, 0, 10'd2, 0, 1, 1);
        cyc(2, 0, 0, 1, 10'd15, 0, 10'd11, 0, 1, 1);
        cyc(2, 1, 1, 0, 0, 0, 10'd8, 0, 1, 1);
        cyc(2, 1, 0, 0, 0, 1, 10'd11, 0, 0, 0);
        cyc(2, 1, 0, 0, 0, 0, 10'd4, 1, 1, 0);

        @(negedge clk);
        idle_all();
        n = 0;
        while (q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
